// File: rtl/ycbcr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ycbcr_pkg
//  Description : Shared definitions for the YCbCr coefficient RAM sequencer:
//                default geometry of the coefficient RAM, controller state
//                encoding and a helper that sizes a table fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
package ycbcr_pkg;

    // Default geometry of the 512x8 coefficient RAM and the coefficient table
    localparam int c_addr_w    = 9;
    localparam int c_data_w    = 8;
    localparam int c_num_coef  = 9;
    localparam int c_coef_base = 0;

    // Controller state encoding
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_fetch  = 2'd1;
    localparam logic [1:0] c_st_commit = 2'd2;

    // Number of bytes read per reload: the table itself, plus one trailing
    // checksum byte when the table is protected.
    function automatic int fetch_len(input int num_coef, input bit with_checksum);
        return with_checksum ? num_coef + 1 : num_coef;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ycbcr_coef_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : ycbcr_coef_fetch
//  Description : Generic table loader. On i_start it issues LEN consecutive
//                reads at BASE, BASE+1, ... (one per cycle, registered
//                address/enable) and captures the returned bytes, which arrive
//                one cycle after each read, into a shadow bank. o_done is high
//                in the cycle the last byte is captured.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clk       in   system clock
//    i_resetn  in   asynchronous active-low reset
//    i_start   in   one-cycle start pulse (ignored while a load is running is
//                   the caller's responsibility)
//    o_raddr   out  RAM read address (registered)
//    o_re      out  RAM read enable (registered)
//    i_rdata   in   RAM read data, valid the cycle after o_re
//    o_shadow  out  captured bytes, byte i at [DATA_W*i +: DATA_W]
//    o_done    out  last byte is being captured this cycle
// ============================================================================
module ycbcr_coef_fetch
    import ycbcr_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w,
    parameter int LEN    = c_num_coef,
    parameter int BASE   = c_coef_base
) (
    input  logic                  clk,
    input  logic                  i_resetn,
    input  logic                  i_start,
    output logic [ADDR_W-1:0]     o_raddr,
    output logic                  o_re,
    input  logic [DATA_W-1:0]     i_rdata,
    output logic [LEN*DATA_W-1:0] o_shadow,
    output logic                  o_done
);

    localparam int                c_idx_w = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [c_idx_w-1:0] c_last  = c_idx_w'(LEN - 1);
    localparam logic [c_idx_w-1:0] c_idx_1 = c_idx_w'(1);
    localparam logic [ADDR_W-1:0]  c_base  = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0]  c_addr_1 = ADDR_W'(1);

    logic [ADDR_W-1:0]     r_raddr;
    logic                  r_re;
    logic [c_idx_w-1:0]    r_issue_idx;
    logic                  r_cap_vld;
    logic [c_idx_w-1:0]    r_cap_idx;
    logic [LEN*DATA_W-1:0] r_shadow;

    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_raddr     <= '0;
            r_re        <= 1'b0;
            r_issue_idx <= '0;
            r_cap_vld   <= 1'b0;
            r_cap_idx   <= '0;
            r_shadow    <= '0;
        end else begin
            // Read issue: address wraps naturally in ADDR_W bits
            if (i_start) begin
                r_re        <= 1'b1;
                r_raddr     <= c_base;
                r_issue_idx <= '0;
            end else if (r_re && (r_issue_idx != c_last)) begin
                r_raddr     <= r_raddr + c_addr_1;
                r_issue_idx <= r_issue_idx + c_idx_1;
            end else begin
                r_re        <= 1'b0;
            end

            // Capture: data for a read issued in cycle t is on i_rdata in t+1
            r_cap_vld <= r_re;
            if (r_cap_vld) begin
                r_shadow[r_cap_idx*DATA_W +: DATA_W] <= i_rdata;
                r_cap_idx <= r_cap_idx + c_idx_1;
            end
            if (i_start) begin
                r_cap_idx <= '0;
            end
        end
    end

    assign o_raddr  = r_raddr;
    assign o_re     = r_re;
    assign o_shadow = r_shadow;
    assign o_done   = r_cap_vld && (r_cap_idx == c_last);

endmodule
`default_nettype wire

// File: rtl/ycbcr_coef_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ycbcr_coef_ctrl
//  Description : Sequencer/arbiter for the YCbCr coefficient block RAM. Shares
//                the RAM between host configuration writes and a fetch engine
//                that reloads the coefficient bank at frame start when the
//                bank is dirty (or was never loaded), then commits the whole
//                bank at once to the YCbCr-to-RGB converter.
//  Revision    : 1.0 - initial release
//
//  Build option: YCBCR_COEF_CHECKSUM_EN
//    Adds a checksum byte at COEF_BASE+NUM_COEF. The bank is committed only
//    when the byte sum of the table (mod 256) matches it; otherwise the old
//    bank is kept, the bank is re-marked dirty and coef_err pulses.
//
//  Ports:
//    clk          in   system clock
//    resetn       in   asynchronous active-low reset
//    frame_start  in   one-cycle pulse at start of frame
//    wr_valid     in   host write request
//    wr_ready     out  host write accepted when wr_valid & wr_ready
//    wr_addr      in   host write address
//    wr_data      in   host write data
//    ram_waddr    out  RAM write address (registered)
//    ram_wdata    out  RAM write data (registered)
//    ram_we       out  RAM write enable (registered)
//    ram_raddr    out  RAM read address (registered)
//    ram_re       out  RAM read enable (registered)
//    ram_rdata    in   RAM read data, valid one clk after ram_re
//    coef         out  committed bank, coefficient i at [8i+7:8i]
//    coef_valid   out  bank holds a committed load
//    busy         out  fetch/commit in progress
//    coef_err     out  checksum mismatch pulse (checksum build only)
// ============================================================================
module ycbcr_coef_ctrl
    import ycbcr_pkg::*;
#(
    parameter int ADDR_W    = c_addr_w,
    parameter int DATA_W    = c_data_w,
    parameter int NUM_COEF  = c_num_coef,
    parameter int COEF_BASE = c_coef_base
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       frame_start,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [ADDR_W-1:0]          ram_waddr,
    output logic [DATA_W-1:0]          ram_wdata,
    output logic                       ram_we,
    output logic [ADDR_W-1:0]          ram_raddr,
    output logic                       ram_re,
    input  logic [DATA_W-1:0]          ram_rdata,
    output logic [NUM_COEF*DATA_W-1:0] coef,
    output logic                       coef_valid,
    output logic                       busy
`ifdef YCBCR_COEF_CHECKSUM_EN
    ,
    output logic                       coef_err
`endif
);

`ifdef YCBCR_COEF_CHECKSUM_EN
    localparam int c_fetch_len = fetch_len(NUM_COEF, 1'b1);
`else
    localparam int c_fetch_len = fetch_len(NUM_COEF, 1'b0);
`endif
    localparam logic [ADDR_W-1:0] c_base    = ADDR_W'(COEF_BASE);
    localparam logic [ADDR_W-1:0] c_win_len = ADDR_W'(c_fetch_len);

    logic [1:0]                     r_state;
    logic [NUM_COEF*DATA_W-1:0]     r_coef;
    logic                           r_coef_valid;
    logic                           r_busy;
    logic                           r_dirty;
    logic                           r_we;
    logic [ADDR_W-1:0]              r_waddr;
    logic [DATA_W-1:0]              r_wdata;

    logic                           w_wr_ready;
    logic                           w_wr_acc;
    logic [ADDR_W-1:0]              w_wr_off;
    logic                           w_in_win;
    logic                           w_fetch_start;
    logic                           w_fetch_done;
    logic [c_fetch_len*DATA_W-1:0]  w_shadow;

    // Fetch wins a same-cycle collision with a host write
    assign w_wr_ready = (r_state == c_st_idle) && !frame_start;
    assign w_wr_acc   = wr_valid && w_wr_ready;

    // Offset compare keeps the window test correct when it wraps past the
    // top of the address space.
    assign w_wr_off = wr_addr - c_base;
    assign w_in_win = (w_wr_off < c_win_len);

    assign w_fetch_start = (r_state == c_st_idle) && frame_start &&
                           (r_dirty || !r_coef_valid);

    ycbcr_coef_fetch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN    (c_fetch_len),
        .BASE   (COEF_BASE)
    ) u_fetch (
        .clk      (clk),
        .i_resetn (resetn),
        .i_start  (w_fetch_start),
        .o_raddr  (ram_raddr),
        .o_re     (ram_re),
        .i_rdata  (ram_rdata),
        .o_shadow (w_shadow),
        .o_done   (w_fetch_done)
    );

`ifdef YCBCR_COEF_CHECKSUM_EN
    logic [DATA_W-1:0] w_sum;
    logic              w_sum_ok;
    logic              r_coef_err;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_COEF; i++) begin
            w_sum = w_sum + w_shadow[i*DATA_W +: DATA_W];
        end
    end

    assign w_sum_ok = (w_sum == w_shadow[NUM_COEF*DATA_W +: DATA_W]);
    assign coef_err = r_coef_err;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= c_st_idle;
            r_coef       <= '0;
            r_coef_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_dirty      <= 1'b1;   // guarantees the first frame loads
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
`ifdef YCBCR_COEF_CHECKSUM_EN
            r_coef_err   <= 1'b0;
`endif
        end else begin
            // Host write path: one registered RAM write per accepted request
            r_we <= w_wr_acc;
            if (w_wr_acc) begin
                r_waddr <= wr_addr;
                r_wdata <= wr_data;
            end
`ifdef YCBCR_COEF_CHECKSUM_EN
            r_coef_err <= 1'b0;
`endif

            case (r_state)
                c_st_idle: begin
                    if (w_fetch_start) begin
                        r_state <= c_st_fetch;
                        r_busy  <= 1'b1;
                        r_dirty <= 1'b0;
                    end else if (w_wr_acc && w_in_win) begin
                        r_dirty <= 1'b1;
                    end
                end
                c_st_fetch: begin
                    if (w_fetch_done) begin
                        r_state <= c_st_commit;
                    end
                end
                c_st_commit: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
`ifdef YCBCR_COEF_CHECKSUM_EN
                    if (w_sum_ok) begin
                        r_coef       <= w_shadow[NUM_COEF*DATA_W-1:0];
                        r_coef_valid <= 1'b1;
                    end else begin
                        r_dirty    <= 1'b1;
                        r_coef_err <= 1'b1;
                    end
`else
                    r_coef       <= w_shadow[NUM_COEF*DATA_W-1:0];
                    r_coef_valid <= 1'b1;
`endif
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready   = w_wr_ready;
    assign ram_we     = r_we;
    assign ram_waddr  = r_waddr;
    assign ram_wdata  = r_wdata;
    assign coef       = r_coef;
    assign coef_valid = r_coef_valid;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ycbcr_coef_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ycbcr_coef_ctrl
//  Description : Directed self-checking bench for ycbcr_coef_ctrl with a
//                512x8 synchronous RAM model and a byte-level reference copy
//                of the table contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ycbcr_coef_ctrl;

`ifdef YCBCR_COEF_CHECKSUM_EN
    localparam int c_nrd = 10;
`else
    localparam int c_nrd = 9;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        frame_start = 1'b0;
    logic        wr_valid = 1'b0;
    logic [8:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_ready;
    logic [8:0]  ram_waddr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [8:0]  ram_raddr;
    logic        ram_re;
    logic [7:0]  ram_rdata;
    logic [71:0] coef;
    logic        coef_valid;
    logic        busy;
    logic        coef_err;
    logic        load_en = 1'b1;

    logic [7:0]  mem [0:511];
    logic [7:0]  mdl [0:511];

    int errors = 0;
    int checks = 0;

    ycbcr_coef_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .frame_start (frame_start),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .ram_waddr   (ram_waddr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .ram_raddr   (ram_raddr),
        .ram_re      (ram_re),
        .ram_rdata   (ram_rdata),
        .coef        (coef),
        .coef_valid  (coef_valid),
        .busy        (busy)
`ifdef YCBCR_COEF_CHECKSUM_EN
        ,
        .coef_err    (coef_err)
`endif
    );

`ifndef YCBCR_COEF_CHECKSUM_EN
    assign coef_err = 1'b0;
`endif

    always #5 clk = ~clk;

    // Synchronous RAM: read-before-write on a same-address collision
    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 512; i++) mem[i] <= mdl[i];
        end else if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] exp_coef();
        logic [71:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r[i*8 +: 8] = mdl[i];
        return r;
    endfunction

    function automatic logic [7:0] exp_sum();
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < 9; i++) s = s + mdl[i];
        return s;
    endfunction

    task automatic host_write(input string tag, input logic [8:0] a, input logic [7:0] d);
        int k;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        k = 0;
        while (!wr_ready && k < 50) begin
            tick();
            k++;
        end
        tick();
        wr_valid = 1'b0;
        mdl[a] = d;
        chk({tag, "_we"}, {63'd0, ram_we, ram_waddr}, {63'd0, 1'b1, a});
        chk({tag, "_wdata"}, {64'd0, ram_wdata}, {64'd0, d});
        tick();
    endtask

    task automatic fix_sum();
`ifdef YCBCR_COEF_CHECKSUM_EN
        host_write("sumfix", 9'd9, exp_sum());
`endif
    endtask

    task automatic run_frame(output int nb, output int nr, output int ne, output bit stable);
        logic [71:0] c0;
        c0 = coef;
        nb = 0; nr = 0; ne = 0; stable = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy) begin
                nb++;
                if (coef !== c0) stable = 1'b0;
            end
            if (ram_re) nr++;
            if (coef_err) ne++;
            tick();
        end
    endtask

    initial begin
        int nb, nr, ne, k;
        bit stable;
        logic [71:0] exp_a;
        logic [71:0] prev;

        for (int i = 0; i < 512; i++) mdl[i] = 8'h00;
        mdl[0] = 8'h51; mdl[1] = 8'h5a; mdl[2] = 8'hf0;
        mdl[3] = 8'h90; mdl[4] = 8'h35; mdl[5] = 8'h22;
        mdl[6] = 8'h28; mdl[7] = 8'hf0; mdl[8] = 8'h6d;
`ifdef YCBCR_COEF_CHECKSUM_EN
        mdl[9] = exp_sum();
`endif

        // Reset state
        tick(); tick();
        load_en = 1'b0;
        chk("rst_coef", coef, 72'd0);
        chk("rst_valid_busy", {70'd0, coef_valid, busy}, 72'd0);
        chk("rst_ram", {41'd0, ram_we, ram_re, ram_waddr, ram_wdata, ram_raddr}, 72'd0);
        chk("rst_wr_ready", {71'd0, wr_ready}, 72'd1);

        // First load after reset
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        run_frame(nb, nr, ne, stable);
        chk("load1_busy", nb, c_nrd + 2);
        chk("load1_reads", nr, c_nrd);
        chk("load1_coef", coef, 72'h6df028223590f05a51);
        chk("load1_valid", {71'd0, coef_valid}, 72'd1);
        chk("load1_stable", {71'd0, stable}, 72'd1);

        // Clean bank: frame_start is ignored
        run_frame(nb, nr, ne, stable);
        chk("clean_busy", nb, 0);
        chk("clean_reads", nr, 0);

        // Write inside the window forces a reload
        host_write("w3", 9'd3, 8'h80);
        fix_sum();
        prev = coef;
        run_frame(nb, nr, ne, stable);
        chk("w3_busy", nb, c_nrd + 2);
        chk("w3_coef", coef, exp_coef());
        chk("w3_byte3", {64'd0, coef[31:24]}, 72'h80);
        chk("w3_held", {71'd0, stable}, 72'd1);
        chk("w3_changed", {71'd0, (coef !== prev)}, 72'd1);

        // Write outside the window leaves the bank clean
        host_write("w100", 9'd100, 8'h33);
        run_frame(nb, nr, ne, stable);
        chk("w100_busy", nb, 0);
        chk("w100_reads", nr, 0);

        // Collision: frame_start and write in the same IDLE cycle
        host_write("w5", 9'd5, 8'h11);
        fix_sum();
        exp_a = exp_coef();
        frame_start = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 9'd2;
        wr_data  = 8'h77;
        #1;
        chk("col_wr_ready", {71'd0, wr_ready}, 72'd0);
        tick();
        frame_start = 1'b0;
        chk("col_busy", {71'd0, busy}, 72'd1);
        k = 0;
        while (!wr_ready && k < 50) begin
            tick();
            k++;
        end
        chk("col_wait", k, c_nrd + 2);
        tick();
        wr_valid = 1'b0;
        chk("col_we", {63'd0, ram_we, ram_waddr}, {63'd0, 1'b1, 9'd2});
        mdl[2] = 8'h77;
        tick();
        chk("col_coef", coef, exp_a);
        fix_sum();
        run_frame(nb, nr, ne, stable);
        chk("col_reload_busy", nb, c_nrd + 2);
        chk("col_reload_coef", coef, exp_coef());

        // Reset during the 4th read issue
        host_write("w0", 9'd0, mdl[0]);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick(); tick(); tick();
        chk("mid_issue4", {62'd0, ram_re, ram_raddr}, {62'd0, 1'b1, 9'd3});
        resetn = 1'b0;
        #1;
        chk("mid_rst_coef", coef, 72'd0);
        chk("mid_rst_flags", {69'd0, coef_valid, busy, ram_re}, 72'd0);
        tick();
        resetn = 1'b1;
        tick();
        run_frame(nb, nr, ne, stable);
        chk("mid_reload_busy", nb, c_nrd + 2);
        chk("mid_reload_coef", coef, exp_coef());
        chk("mid_reload_valid", {71'd0, coef_valid}, 72'd1);

`ifdef YCBCR_COEF_CHECKSUM_EN
        // Wrong checksum: old bank kept, error pulse
        prev = coef;
        host_write("badsum", 9'd9, ~exp_sum());
        run_frame(nb, nr, ne, stable);
        chk("bad_err", ne, 1);
        chk("bad_coef", coef, prev);
        chk("bad_valid", {71'd0, coef_valid}, 72'd1);
        // Correct checksum: commits on the next frame
        host_write("w1", 9'd1, 8'h3c);
        fix_sum();
        run_frame(nb, nr, ne, stable);
        chk("good_err", ne, 0);
        chk("good_coef", coef, exp_coef());
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
